// File: rtl/display_scan.sv
// Multiplexed seven-segment scan driver: steps through digits on timer ticks,
// inserting an all-anodes-off gap before each digit to suppress ghosting.
module display_scan #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned BLANK_CYCLES = 4,
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scan_enable,
    input  logic                    scan_tick,
    input  logic [4*NUM_DIGITS-1:0] display_value,
    input  logic [NUM_DIGITS-1:0]   display_dp,
    input  logic [NUM_DIGITS-1:0]   display_enable,
    output logic                    scan_tick_clear,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [6:0]              segment_n,
    output logic                    dp_n,
    output logic [IDX_W-1:0]        digit_index
);

    typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

    state_e     state_q;
    logic [7:0] blank_cnt_q;
    logic       tick_edge;
    logic [3:0] cur_nibble;
    logic       cur_dp;
    logic       cur_en;
    logic [IDX_W-1:0] next_index;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // scan_tick_clear doubles as the previous tick sample for edge detection.
    always_comb begin
        tick_edge  = scan_tick & ~scan_tick_clear;
        cur_nibble = display_value[{digit_index, 2'b00} +: 4];
        cur_dp     = display_dp[digit_index];
        cur_en     = display_enable[digit_index];
        next_index = (digit_index == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_index + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StIdle;
            blank_cnt_q     <= 8'd0;
            digit_index     <= '0;
            anode_n         <= '1;
            segment_n       <= 7'h7F;
            dp_n            <= 1'b1;
            scan_tick_clear <= 1'b0;
        end else begin
            scan_tick_clear <= scan_tick;
            if (!scan_enable) begin
                state_q     <= StIdle;
                digit_index <= '0;
                anode_n     <= '1;
                segment_n   <= 7'h7F;
                dp_n        <= 1'b1;
            end else begin
                case (state_q)
                    StIdle: begin
                        state_q     <= StBlank;
                        blank_cnt_q <= 8'(BLANK_CYCLES);
                    end
                    StBlank: begin
                        blank_cnt_q <= blank_cnt_q - 8'd1;
                        // Snapshot the digit on the last blank cycle so the slot is stable.
                        if (blank_cnt_q <= 8'd1) begin
                            state_q   <= StShow;
                            anode_n   <= cur_en ? ~(NUM_DIGITS'(1) << digit_index) : '1;
                            segment_n <= hex_to_seg(cur_nibble);
                            dp_n      <= ~cur_dp;
                        end
                    end
                    StShow: begin
                        if (tick_edge) begin
                            state_q     <= StBlank;
                            blank_cnt_q <= 8'(BLANK_CYCLES);
                            digit_index <= next_index;
                            anode_n     <= '1;
                            segment_n   <= 7'h7F;
                            dp_n        <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/display_scan.md
# display_scan

Multiplexed seven-segment scan driver for the display subsystem. Sits directly downstream of the display timer: each timer interrupt advances the active digit, and the block returns a one-cycle clear so the timer can re-arm. It drives active-low anode and segment lines with a programmable blanking gap between digits to suppress ghosting. Digit values, decimal points and per-digit enables come from the display register bank.

## Interface
- NUM_DIGITS, 8, number of multiplexed digits (2..8)
- BLANK_CYCLES, 4, all-anodes-off cycles inserted before each digit is shown (1..255; 8-bit counter)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- scan_enable  in  1  1 = scanning; 0 = display dark, digit index held at 0
- scan_tick  in  1  timer interrupt (level; may stay high several cycles)
- display_value  in  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i]
- display_dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- display_enable  in  NUM_DIGITS  1 = digit lit when selected; 0 = digit stays dark for its slot
- scan_tick_clear  out  1  one-cycle clear back to the timer
- anode_n  out  NUM_DIGITS  active-low digit select; at most one bit low
- segment_n  out  7  active-low segments {g,f,e,d,c,b,a}
- dp_n  out  1  active-low decimal point
- digit_index  out  clog2(NUM_DIGITS) (min 1)  currently selected digit

## Operation
- States: IDLE, BLANK, SHOW.
- IDLE: anode_n all 1, segment_n 7'h7F, dp_n 1, digit_index 0. scan_enable=1 -> BLANK, counter loaded with BLANK_CYCLES.
- BLANK: anode_n all 1; counter decrements each cycle; on reaching 0 -> SHOW. On that transition the selected digit's nibble, dp and enable bit are snapshotted into output registers; later input changes do not affect the digit until its next slot.
- SHOW: anode_n[digit_index]=0 if the snapshotted enable is 1, else all 1; segment_n = hex decode of snapshot; dp_n = ~dp. Stays until a tick edge.
- Tick edge: scan_tick=1 and registered previous sample=0. In SHOW an edge -> BLANK, digit_index increments (NUM_DIGITS-1 wraps to 0), counter reloaded. Edges in BLANK or IDLE are ignored (no advance).
- Tick clear: scan_tick_clear = registered copy of scan_tick, in every state, so a held interrupt is cleared even when no advance occurs.
- scan_enable=0 in any state -> IDLE next cycle; digit_index forced to 0; outputs dark.
- Hex decode (segment_n): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
- Reset: state IDLE, digit_index 0, anode_n all 1, segment_n 7'h7F, dp_n 1, scan_tick_clear 0, tick history 0, counter 0.

## Timing
- All outputs registered; no combinational input-to-output paths.
- scan_enable rising at cycle T -> BLANK at T+1 -> SHOW digit 0 at T+1+BLANK_CYCLES.
- Tick edge sampled at T in SHOW -> anodes off and digit_index+1 at T+1; new digit lit at T+1+BLANK_CYCLES.
- scan_tick high at T -> scan_tick_clear high at T+1; clear lasts exactly as many cycles as scan_tick was high.
- Tick held high for k cycles: exactly one advance.
- Tick edge in the same cycle as scan_enable falling: enable wins, IDLE, no advance.
- Reset mid-scan: all outputs return to reset values next cycle regardless of state.

## Test plan
- Reset: assert reset 2 cycles with scan_tick=1 -> anode_n all 1, segment_n 7F, dp_n 1, digit_index 0, scan_tick_clear 0.
- Basic scan (NUM_DIGITS=4, BLANK_CYCLES=2): value 0x1A8F, enable 4'hF, dp 4'b0010, scan_enable=1, one-cycle ticks every 20 cycles -> digit 0 shows 0E after 3 cycles, then digit 1 shows 00 with dp_n=0, digit 2 shows 08, digit 3 shows 79, then wrap to digit 0; 2 dark cycles between each.
- Held tick: scan_tick high 5 cycles in SHOW -> one advance; scan_tick_clear high 5 cycles delayed by 1.
- Disabled digit: enable 4'b1011 -> digit 2 slot keeps anode_n=4'hF for its full slot; digit_index still reaches 2.
- Tick during BLANK: edge 1 cycle after an advance -> ignored, clear still pulses, index unchanged.
- scan_enable dropped while digit 3 shown -> next cycle IDLE, dark, digit_index 0; re-enable -> digit 0 after BLANK_CYCLES+1.
